// File: rtl/fp_mul_status_gen_pkg.sv
// +--------------------------------------------------------------------+
// | fp_status_pkg: operand classes, status bit indices, helpers          |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package fp_status_pkg;

  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    DENORM = 3'd1,
    NORMAL = 3'd2,
    INF    = 3'd3,
    NAN    = 3'd4
  } fp_cls_t;

  localparam int ST_ZERO    = 0;
  localparam int ST_INF     = 1;
  localparam int ST_NAN     = 2;
  localparam int ST_TINY    = 3;
  localparam int ST_HUGE    = 4;
  localparam int ST_INEXACT = 5;

  function automatic int exp_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_mul_status_gen_classify.sv
// +--------------------------------------------------------------------+
// | fp_status_classify: combinational product status classification    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module fp_status_classify
  import fp_status_pkg::*;
#(
  parameter int EXP_W = 8
) (
  input  fp_cls_t                 a_cls_i,
  input  fp_cls_t                 b_cls_i,
  input  logic signed [EXP_W+1:0] exp_i,
  input  logic                    inexact_i,
  output logic [7:0]              status_o
);

  localparam logic signed [EXP_W+1:0] C_EXP_MAX  = (EXP_W+2)'(exp_max(EXP_W));
  localparam logic signed [EXP_W+1:0] C_EXP_ZERO = '0;

  logic w_any_nan;
  logic w_any_inf;
  logic w_any_zero;

  assign w_any_nan  = (a_cls_i == NAN) || (b_cls_i == NAN);
  assign w_any_inf  = (a_cls_i == INF) || (b_cls_i == INF);
  assign w_any_zero = (a_cls_i == ZERO) || (b_cls_i == ZERO);

  // Priority chain guarantees at most one of bits [4:0] is set.
  always_comb begin
    status_o = '0;
    if (w_any_nan || (w_any_zero && w_any_inf)) begin
      status_o[ST_NAN] = 1'b1;
    end else if (w_any_inf) begin
      status_o[ST_INF] = 1'b1;
    end else if (w_any_zero) begin
      status_o[ST_ZERO] = 1'b1;
    end else if (exp_i >= C_EXP_MAX) begin
      status_o[ST_HUGE]    = 1'b1;
      status_o[ST_INEXACT] = 1'b1;
    end else if (exp_i <= C_EXP_ZERO) begin
      status_o[ST_TINY]    = 1'b1;
      status_o[ST_INEXACT] = 1'b1;
    end else begin
      status_o[ST_INEXACT] = inexact_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fp_mul_status_gen.sv
// +--------------------------------------------------------------------+
// | fp_mul_status_gen: registered FP multiplier status word with       |
// | valid/ready stage, sticky flags and saturating exception counter.  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module fp_mul_status_gen
  import fp_status_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  fp_cls_t                 a_cls_i,
  input  fp_cls_t                 b_cls_i,
  input  logic signed [EXP_W+1:0] exp_i,
  input  logic                    inexact_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [7:0]              status_o,
  output logic [5:0]              sticky_o,
  input  logic                    sticky_clr_i,
  output logic [CNT_W-1:0]        exc_cnt_o
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [7:0]       w_status;
  logic             w_accept;
  logic             w_xfer;
  logic             w_exc;
  logic [5:0]       w_sticky_base;
  logic [CNT_W-1:0] w_cnt_base;

  logic             out_valid_d, out_valid_q;
  logic [7:0]       status_d, status_q;
  logic [5:0]       sticky_d, sticky_q;
  logic [CNT_W-1:0] exc_cnt_d, exc_cnt_q;

  fp_status_classify #(
    .EXP_W (EXP_W)
  ) u_classify (
    .a_cls_i   (a_cls_i),
    .b_cls_i   (b_cls_i),
    .exp_i     (exp_i),
    .inexact_i (inexact_i),
    .status_o  (w_status)
  );

  assign in_ready_o = !out_valid_q || out_ready_i;
  assign w_accept   = in_valid_i && in_ready_o;
  assign w_xfer     = out_valid_q && out_ready_i;
  assign w_exc      = status_q[ST_NAN] | status_q[ST_TINY] | status_q[ST_HUGE];

  // A clear drops old contents, but a word leaving this edge still counts.
  assign w_sticky_base = sticky_clr_i ? 6'd0 : sticky_q;
  assign w_cnt_base    = sticky_clr_i ? '0 : exc_cnt_q;

  always_comb begin
    out_valid_d = out_valid_q;
    status_d    = status_q;
    sticky_d    = w_sticky_base;
    exc_cnt_d   = w_cnt_base;
    if (w_accept) begin
      out_valid_d = 1'b1;
      status_d    = w_status;
    end else if (w_xfer) begin
      out_valid_d = 1'b0;
    end
    if (w_xfer) begin
      sticky_d = w_sticky_base | status_q[5:0];
      if (w_exc && (w_cnt_base != C_CNT_MAX)) begin
        exc_cnt_d = w_cnt_base + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      status_q    <= '0;
      sticky_q    <= '0;
      exc_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      status_q    <= status_d;
      sticky_q    <= sticky_d;
      exc_cnt_q   <= exc_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign status_o    = status_q;
  assign sticky_o    = sticky_q;
  assign exc_cnt_o   = exc_cnt_q;

  a_status_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                    $onehot0(status_q[4:0]));

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_status_gen.sv
// +--------------------------------------------------------------------+
// | tb_fp_mul_status_gen: table vectors, corner sequences, random run   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fp_mul_status_gen;
  import fp_status_pkg::*;

  localparam int EXP_W = 8;
  localparam int CNT_W = 2;
  localparam int C_CNT_MAX = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  fp_cls_t                 a_cls = NORMAL;
  fp_cls_t                 b_cls = NORMAL;
  logic signed [EXP_W+1:0] exp_v = '0;
  logic                    inexact = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [7:0]              status;
  logic [5:0]              sticky;
  logic                    sticky_clr = 1'b0;
  logic [CNT_W-1:0]        exc_cnt;

  int n_pass = 0;
  int n_total = 0;

  // Reference state of the output stage
  bit       m_valid = 0;
  bit [7:0] m_status = '0;
  bit [5:0] m_sticky = '0;
  int       m_cnt = 0;

  always #5 clk = ~clk;

  fp_mul_status_gen #(.EXP_W(EXP_W), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .a_cls_i      (a_cls),
    .b_cls_i      (b_cls),
    .exp_i        (exp_v),
    .inexact_i    (inexact),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .status_o     (status),
    .sticky_o     (sticky),
    .sticky_clr_i (sticky_clr),
    .exc_cnt_o    (exc_cnt)
  );

  function automatic bit [7:0] ref_status(fp_cls_t a, fp_cls_t b, int e, bit inex);
    bit [7:0] s = '0;
    bit nan  = (a == NAN) || (b == NAN) || (a == ZERO && b == INF) || (a == INF && b == ZERO);
    bit inf  = (a == INF) || (b == INF);
    bit zero = (a == ZERO) || (b == ZERO);
    if (nan)                       s = 8'h04;
    else if (inf)                  s = 8'h02;
    else if (zero)                 s = 8'h01;
    else if (e >= 2**EXP_W - 1)    s = 8'h30;
    else if (e <= 0)               s = 8'h28;
    else                           s = inex ? 8'h20 : 8'h00;
    return s;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    else n_pass++;
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("status", 32'(status), 32'(m_status));
    chk("sticky", 32'(sticky), 32'(m_sticky));
    chk("exc_cnt", 32'(exc_cnt), 32'(m_cnt));
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    chk("onehot", 32'($countones(status[4:0]) <= 1), 32'd1);
  endtask

  // One clock: predict the edge from the current inputs, then compare.
  task automatic cycle();
    bit       rdy = !m_valid || out_ready;
    bit       acc = in_valid && rdy;
    bit       xf  = m_valid && out_ready;
    bit [7:0] nw  = ref_status(a_cls, b_cls, int'(exp_v), inexact);
    @(posedge clk);
    #1;
    if (sticky_clr) begin
      m_sticky = '0;
      m_cnt = 0;
    end
    if (xf) begin
      m_sticky |= m_status[5:0];
      if ((m_status[2] || m_status[3] || m_status[4]) && m_cnt < C_CNT_MAX) m_cnt++;
    end
    if (acc) begin
      m_valid = 1;
      m_status = nw;
    end else if (xf) begin
      m_valid = 0;
    end
    compare_all();
  endtask

  task automatic drive(input fp_cls_t a, input fp_cls_t b, input int e, input bit inex);
    a_cls = a;
    b_cls = b;
    exp_v = (EXP_W+2)'(e);
    inexact = inex;
  endtask

  typedef struct {
    fp_cls_t  a;
    fp_cls_t  b;
    int       e;
    bit       inex;
    bit [7:0] req;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{NORMAL, NORMAL, 130,  1'b1, 8'h20};
    vecs[1]  = '{ZERO,   INF,    100,  1'b1, 8'h04};
    vecs[2]  = '{NAN,    ZERO,   100,  1'b0, 8'h04};
    vecs[3]  = '{INF,    NORMAL, 300,  1'b1, 8'h02};
    vecs[4]  = '{ZERO,   DENORM, -5,   1'b1, 8'h01};
    vecs[5]  = '{NORMAL, NORMAL, 255,  1'b0, 8'h30};
    vecs[6]  = '{DENORM, NORMAL, -3,   1'b0, 8'h28};
    vecs[7]  = '{NORMAL, NORMAL, 1,    1'b0, 8'h00};
    vecs[8]  = '{NORMAL, DENORM, 254,  1'b0, 8'h00};
    vecs[9]  = '{NORMAL, NORMAL, 0,    1'b0, 8'h28};
    vecs[10] = '{INF,    ZERO,   10,   1'b0, 8'h04};
    vecs[11] = '{NORMAL, NORMAL, 511,  1'b0, 8'h30};
    vecs[12] = '{NORMAL, NORMAL, -512, 1'b1, 8'h28};
    vecs[13] = '{DENORM, DENORM, 256,  1'b0, 8'h30};

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_sticky", 32'(sticky), 32'd0);
    chk("rst_exc_cnt", 32'(exc_cnt), 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Table vectors, back-to-back at full throughput
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].inex);
      cycle();
      chk($sformatf("vec%0d_status", i), 32'(status), 32'(vecs[i].req));
      if (i == 1) chk("vec0_sticky", 32'(sticky), 32'h20);
      if (i == 4) chk("nan_only_cnt", 32'(exc_cnt), 32'd2);
    end
    in_valid = 1'b0;
    cycle();

    // Stall: one word held for 5 cycles while a second bundle waits
    sticky_clr = 1'b1;
    cycle();
    sticky_clr = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(NORMAL, NORMAL, 130, 1'b1);
    cycle();
    drive(INF, NORMAL, 50, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_status", 32'(status), 32'h20);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    cycle();
    chk("stall_second_word", 32'(status), 32'h02);
    chk("stall_first_sticky", 32'(sticky), 32'h20);
    in_valid = 1'b0;
    cycle();
    chk("stall_drained", 32'(out_valid), 32'd0);

    // Counter saturation, then clear coincident with a tiny transfer
    in_valid = 1'b1;
    drive(NAN, NORMAL, 100, 1'b0);
    for (int i = 0; i < 5; i++) cycle();
    in_valid = 1'b0;
    cycle();
    chk("cnt_saturated", 32'(exc_cnt), 32'd3);
    in_valid = 1'b1;
    drive(NORMAL, NORMAL, -3, 1'b0);
    cycle();
    in_valid   = 1'b0;
    sticky_clr = 1'b1;
    cycle();
    sticky_clr = 1'b0;
    chk("clr_xfer_sticky", 32'(sticky), 32'h28);
    chk("clr_xfer_cnt", 32'(exc_cnt), 32'd1);

    // Asynchronous reset with a pending word
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(NORMAL, NORMAL, 300, 1'b0);
    cycle();
    chk("pending_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    m_valid = 0;
    m_status = '0;
    m_sticky = '0;
    m_cnt = 0;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_status", 32'(status), 32'd0);
    chk("async_rst_sticky", 32'(sticky), 32'd0);
    chk("async_rst_cnt", 32'(exc_cnt), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Randomized run against the reference model
    for (int i = 0; i < 400; i++) begin
      int e;
      case ($urandom_range(0, 3))
        0: e = $urandom_range(0, 1023) - 512;
        1: e = $urandom_range(250, 260);
        2: e = $urandom_range(0, 6) - 3;
        default: e = $urandom_range(1, 254);
      endcase
      drive(fp_cls_t'($urandom_range(0, 4)), fp_cls_t'($urandom_range(0, 4)), e,
            1'($urandom_range(0, 1)));
      in_valid   = 1'($urandom_range(0, 3) != 0);
      out_ready  = 1'($urandom_range(0, 3) != 0);
      sticky_clr = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
